// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C transfer arbiter and its round-robin picker.
package i2c_arb_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int RETRY_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  // One latched controller transaction: 8-bit write address plus {register, payload}.
  typedef struct packed {
    logic [ADDR_W-1:0] slave;
    logic [DATA_W-1:0] data;
  } xfer_t;

endpackage

// File: rtl/i2c_transfer_arbiter_rr_picker.sv
// Combinational round-robin picker: the search starts one slot after the last grant.
module rr_picker
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               valid_o
);

  always_comb begin
    int               slot;
    logic [IDX_W-1:0] sel;
    logic             found;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    slot        = 0;
    sel         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      slot = (int'(last_grant_i) + i) % NUM_REQ;
      sel  = IDX_W'(slot);
      if (!found && req_valid_i[sel]) begin
        found           = 1'b1;
        grant_oh_o[sel] = 1'b1;
        grant_idx_o     = sel;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/i2c_transfer_arbiter.sv
// Round-robin arbiter sharing one I2C byte-transfer controller, with NACK retry.
// Optional per-attempt watchdog is built only when I2C_ARB_TIMEOUT_EN is defined.
module i2c_transfer_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int MAX_RETRY      = 3,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clock_25,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_slave,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_nack,
  output logic                      rsp_timeout,
  output logic                      ctl_start,
  output logic [ADDR_W-1:0]         ctl_slave_address,
  output logic [DATA_W-1:0]         ctl_register_data,
  input  logic                      ctl_stop,
  input  logic                      ctl_ack,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  arb_state_e          state_q;
  logic [IDX_W-1:0]    last_grant_q;
  logic [IDX_W-1:0]    grant_idx_q;
  logic [NUM_REQ-1:0]  grant_oh_q;
  logic [RETRY_W-1:0]  retry_q;
  logic [GAP_W-1:0]    gap_q;
  logic                reissue_q;
  logic                fail_nack_q;
  logic                fail_to_q;
  xfer_t               xfer_q;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic                rsp_nack_q;
  logic                rsp_to_q;
  logic                ctl_start_q;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  xfer_t               pick_xfer;
  logic                timeout_hit;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .grant_oh_o   (pick_oh),
    .grant_idx_o  (pick_idx),
    .valid_o      (pick_valid)
  );

  always_comb begin
    pick_xfer = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (pick_oh[r]) begin
        pick_xfer.slave = req_slave[r*ADDR_W +: ADDR_W];
        pick_xfer.data  = req_data[r*DATA_W +: DATA_W];
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdog_q;

  // Restarts on every attempt: it bounds a single controller transfer, not the retries.
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else if (state_q != WAIT) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 16'd1;
    end
  end

  assign timeout_hit = (state_q == WAIT) && (wdog_q == WDOG_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_idx_q  <= '0;
      grant_oh_q   <= '0;
      retry_q      <= '0;
      gap_q        <= '0;
      reissue_q    <= 1'b0;
      fail_nack_q  <= 1'b0;
      fail_to_q    <= 1'b0;
      xfer_q       <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_nack_q   <= 1'b0;
      rsp_to_q     <= 1'b0;
      ctl_start_q  <= 1'b0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_idx_q <= pick_idx;
            grant_oh_q  <= pick_oh;
            xfer_q      <= pick_xfer;
            req_ready_q <= pick_oh;
            ctl_start_q <= 1'b1;
            retry_q     <= '0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          // A stop in the same cycle as the watchdog expiry wins: the controller did answer.
          if (ctl_stop) begin
            ctl_start_q <= 1'b0;
            gap_q       <= '0;
            fail_to_q   <= 1'b0;
            state_q     <= GAP;
            if (!ctl_ack) begin
              reissue_q   <= 1'b0;
              fail_nack_q <= 1'b0;
            end else if (retry_q < RETRY_LIM) begin
              retry_q     <= retry_q + RETRY_W'(1);
              reissue_q   <= 1'b1;
              fail_nack_q <= 1'b0;
            end else begin
              reissue_q   <= 1'b0;
              fail_nack_q <= 1'b1;
            end
          end else if (timeout_hit) begin
            ctl_start_q <= 1'b0;
            gap_q       <= '0;
            reissue_q   <= 1'b0;
            fail_nack_q <= 1'b0;
            fail_to_q   <= 1'b1;
            state_q     <= GAP;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            if (reissue_q) begin
              ctl_start_q <= 1'b1;
              state_q     <= WAIT;
            end else begin
              rsp_valid_q <= grant_oh_q;
              rsp_nack_q  <= fail_nack_q;
              rsp_to_q    <= fail_to_q;
              state_q     <= RESP;
            end
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        RESP: begin
          rsp_nack_q   <= 1'b0;
          rsp_to_q     <= 1'b0;
          last_grant_q <= grant_idx_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready         = req_ready_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_nack          = rsp_nack_q;
  assign rsp_timeout       = rsp_to_q;
  assign ctl_start         = ctl_start_q;
  assign ctl_slave_address = xfer_q.slave;
  assign ctl_register_data = xfer_q.data;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_transfer_arbiter.sv
// Self-checking bench for i2c_transfer_arbiter: vector table, scoreboard queues and a controller model.
module tb_i2c_transfer_arbiter;

  localparam int NREQ    = 2;
  localparam int MAXR    = 3;
  localparam int GAP     = 4;
  localparam int TOC     = 100;
  localparam int CTL_LAT = 3;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_slave = '0;
  logic [31:0] req_data  = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic        rsp_nack;
  logic        rsp_timeout;
  logic        ctl_start;
  logic [7:0]  ctl_slave;
  logic [15:0] ctl_data;
  logic        ctl_stop  = 1'b0;
  logic        ctl_ack   = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  i2c_transfer_arbiter #(
    .NUM_REQ        (NREQ),
    .MAX_RETRY      (MAXR),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clock_25          (clk),
    .reset_n           (rst_n),
    .req_valid         (req_valid),
    .req_slave         (req_slave),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_nack          (rsp_nack),
    .rsp_timeout       (rsp_timeout),
    .ctl_start         (ctl_start),
    .ctl_slave_address (ctl_slave),
    .ctl_register_data (ctl_data),
    .ctl_stop          (ctl_stop),
    .ctl_ack           (ctl_ack),
    .busy              (busy)
  );

  typedef struct {
    logic [1:0]  oh;
    logic [7:0]  slave;
    logic [15:0] data;
    logic        nack;
    logic        to;
    int          starts;
  } exp_t;

  typedef struct {
    logic [1:0]  mask;
    logic [15:0] d0;
    logic [15:0] d1;
    int          nacks;
    logic [1:0]  first;
    logic        nack;
    int          starts;
  } vec_t;

  exp_t exp_q[$];
  exp_t rsp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int att = 0, nack_each = 0, starts_cur = 0, ctl_cnt = 0, low_run = 1000;
  int rise_cyc = 0, rsp_cyc = 0;
  int refill [2];
  bit hang = 1'b0;
  logic prev_start = 1'b0;
  logic [7:0]  cur_slave = '0;
  logic [15:0] cur_data  = '0;

  function automatic exp_t mk(logic [1:0] oh, logic [7:0] s, logic [15:0] d,
                              logic nk, logic to, int st);
    exp_t e;
    e.oh = oh; e.slave = s; e.data = d; e.nack = nk; e.to = to; e.starts = st;
    return e;
  endfunction

  function automatic vec_t mkv(logic [1:0] mask, logic [15:0] d0, logic [15:0] d1, int nacks,
                               logic [1:0] first, logic nk, int st);
    vec_t v;
    v.mask = mask; v.d0 = d0; v.d1 = d1; v.nacks = nacks;
    v.first = first; v.nack = nk; v.starts = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: sample at the falling edge, score DUT outputs, then run the controller model.
  task automatic tick();
    exp_t e;
    int   r;
    @(negedge clk);
    cyc++;
    if (req_ready != 2'b00) begin
      chk("req_ready_onehot", 32'($onehot(req_ready)), 1);
      if (exp_q.size() == 0) begin
        chk("grant_unexpected", req_ready, 0);
      end else begin
        e = exp_q.pop_front();
        chk("grant_oh", req_ready, e.oh);
        chk("grant_start", ctl_start, 1);
        chk("grant_slave", ctl_slave, e.slave);
        chk("grant_data", ctl_data, e.data);
        rsp_q.push_back(e);
        cur_slave  = e.slave;
        cur_data   = e.data;
        att        = 0;
        starts_cur = 0;
        r = req_ready[1] ? 1 : 0;
        if (refill[r] > 0) begin
          refill[r]--;
          e.data = e.data ^ 16'h0F0F;
          e.oh   = 2'(1 << r);
          req_data[r*16 +: 16] = e.data;
          exp_q.push_back(e);
        end else begin
          req_valid[r] = 1'b0;
        end
      end
    end
    if (ctl_start) begin
      chk("ctl_data_hold", ctl_data, cur_data);
      chk("ctl_slave_hold", ctl_slave, cur_slave);
    end
    if (rsp_valid != 2'b00) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 0);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_oh", rsp_valid, e.oh);
        chk("rsp_nack", rsp_nack, e.nack);
        chk("rsp_timeout", rsp_timeout, e.to);
        chk("rsp_attempts", starts_cur, e.starts);
        rsp_cyc = cyc;
      end
    end
    ctl_stop = 1'b0;
    ctl_ack  = 1'b0;
    if (ctl_start && !prev_start) begin
      chk("gap_low_cycles", 32'(low_run >= GAP), 1);
      starts_cur++;
      rise_cyc = cyc;
      if (!hang) ctl_cnt = CTL_LAT;
    end
    low_run    = ctl_start ? 0 : low_run + 1;
    prev_start = ctl_start;
    if (ctl_cnt > 0) begin
      ctl_cnt--;
      if (ctl_cnt == 0) begin
        ctl_stop = 1'b1;
        ctl_ack  = (att < nack_each);
        att++;
      end
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !(exp_q.size() == 0 && rsp_q.size() == 0 && req_valid == 2'b00 && !busy)) begin
      tick();
      n++;
    end
    chk({name, "_complete"}, 32'(n < budget), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t tbl [8];
    int   f;
    refill[0] = 0;
    refill[1] = 0;
    // Pointer before each row follows the grant history; expectations derived by hand.
    tbl[0] = mkv(2'b10, 16'h4110, 16'h1530,  0, 2'b10, 1'b0, 1);
    tbl[1] = mkv(2'b01, 16'h9801, 16'h0000,  2, 2'b01, 1'b0, 3);
    tbl[2] = mkv(2'b10, 16'h0000, 16'hD6C0, 15, 2'b10, 1'b1, 4);
    tbl[3] = mkv(2'b11, 16'hAF06, 16'h5510,  1, 2'b01, 1'b0, 2);
    tbl[4] = mkv(2'b11, 16'h1602, 16'h1700,  0, 2'b01, 1'b0, 1);
    tbl[5] = mkv(2'b01, 16'hE0D0, 16'h0000,  3, 2'b01, 1'b0, 4);
    tbl[6] = mkv(2'b11, 16'h4A80, 16'h4BFF,  4, 2'b10, 1'b1, 4);
    tbl[7] = mkv(2'b10, 16'h0000, 16'h3B00,  0, 2'b10, 1'b0, 1);

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_nack", rsp_nack, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_ctl_start", ctl_start, 0);
    chk("rst_ctl_slave", ctl_slave, 0);
    chk("rst_ctl_data", ctl_data, 0);
    chk("rst_busy", busy, 0);

    // Single request from requester 0, ACKed first time.
    nack_each = 0;
    req_slave[7:0] = 8'h7A;
    req_data[15:0] = 16'h4110;
    exp_q.push_back(mk(2'b01, 8'h7A, 16'h4110, 1'b0, 1'b0, 1));
    req_valid = 2'b01;
    tick();
    chk("single_ready_latency", req_ready, 2'b01);
    chk("single_start", ctl_start, 1);
    chk("single_data", ctl_data, 16'h4110);
    drain("single", 100);

    for (int i = 0; i < 8; i++) begin
      req_slave = {8'h72, 8'h7A};
      req_data  = {tbl[i].d1, tbl[i].d0};
      nack_each = tbl[i].nacks;
      f = tbl[i].first[1] ? 1 : 0;
      exp_q.push_back(mk(tbl[i].first, f ? 8'h72 : 8'h7A, f ? tbl[i].d1 : tbl[i].d0,
                         tbl[i].nack, 1'b0, tbl[i].starts));
      if (tbl[i].mask == 2'b11)
        exp_q.push_back(mk(~tbl[i].first, f ? 8'h7A : 8'h72, f ? tbl[i].d0 : tbl[i].d1,
                           tbl[i].nack, 1'b0, tbl[i].starts));
      req_valid = tbl[i].mask;
      drain($sformatf("vec%0d", i), 400);
    end

    // Both requesters keep requesting: grants must alternate 0,1,0,1.
    nack_each = 0;
    refill[0] = 1;
    refill[1] = 1;
    req_slave = {8'h72, 8'h7A};
    req_data  = {16'hAA01, 16'h5501};
    exp_q.push_back(mk(2'b01, 8'h7A, 16'h5501, 1'b0, 1'b0, 1));
    exp_q.push_back(mk(2'b10, 8'h72, 16'hAA01, 1'b0, 1'b0, 1));
    req_valid = 2'b11;
    drain("continuous", 400);

    // Leave the pointer at requester 0, then abort a requester-1 transfer with reset.
    req_data[15:0] = 16'h1234;
    exp_q.push_back(mk(2'b01, 8'h7A, 16'h1234, 1'b0, 1'b0, 1));
    req_valid = 2'b01;
    drain("pre_abort", 100);
    hang = 1'b1;
    req_data[31:16] = 16'hBEEF;
    exp_q.push_back(mk(2'b10, 8'h72, 16'hBEEF, 1'b0, 1'b0, 1));
    req_valid = 2'b10;
    tick();
    chk("abort_granted", req_ready, 2'b10);
    repeat (5) tick();
    chk("abort_in_wait", ctl_start, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_start_low", ctl_start, 0);
    chk("abort_busy_low", busy, 0);
    rsp_q.delete();
    exp_q.delete();
    hang      = 1'b0;
    ctl_cnt   = 0;
    req_valid = 2'b00;
    repeat (6) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("abort_no_rsp", rsp_valid, 0);
    req_data = {16'h3333, 16'h2222};
    exp_q.push_back(mk(2'b01, 8'h7A, 16'h2222, 1'b0, 1'b0, 1));
    exp_q.push_back(mk(2'b10, 8'h72, 16'h3333, 1'b0, 1'b0, 1));
    req_valid = 2'b11;
    drain("post_abort", 200);

`ifdef I2C_ARB_TIMEOUT_EN
    // Controller never answers: the watchdog ends the transfer with a timeout status.
    hang = 1'b1;
    req_data[15:0] = 16'h0C0C;
    exp_q.push_back(mk(2'b01, 8'h7A, 16'h0C0C, 1'b0, 1'b1, 1));
    req_valid = 2'b01;
    drain("timeout", 400);
    chk("timeout_latency_min", 32'((rsp_cyc - rise_cyc) >= TOC), 1);
    chk("timeout_latency_max", 32'((rsp_cyc - rise_cyc) <= TOC + GAP + 4), 1);
    hang = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
